// File: rtl/banner_pkg.sv
// Shared constants and scanner state type for the banner row scanner.
// BANNER_GAP_EN appends GAP_W blank columns after the banner, widening the scroll period.
package banner_pkg;

    localparam int WORD_W = 71;
    localparam int ROWS   = 15;
    localparam int ADDR_W = 5;
    localparam int IDX_W  = 4;
    localparam int OFF_W  = 7;
    localparam int GAP_W  = 8;

`ifdef BANNER_GAP_EN
    localparam int VW = WORD_W + GAP_W;
`else
    localparam int VW = WORD_W;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CAPT,
        ST_HOLD,
        ST_FEND
    } scan_state_e;

    // One-column scroll step; wraps from the last virtual column back to 0.
    function automatic logic [OFF_W-1:0] next_offset(input logic [OFF_W-1:0] off);
        logic [OFF_W-1:0] nxt;
        if (off == OFF_W'(VW - 1)) begin
            nxt = '0;
        end else begin
            nxt = off + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/banner_window_extract.sv
// Combinational window cut: WIN_W columns starting at offset, wrapping once at VW.
// With BANNER_GAP_EN the columns beyond the banner word read as 0.
module banner_window_extract
    import banner_pkg::*;
#(
    parameter int WIN_W = 16
) (
    input  logic [WORD_W-1:0] word,
    input  logic [OFF_W-1:0]  offset,
    output logic [WIN_W-1:0]  window
);

    localparam logic [OFF_W-1:0] VW_C = OFF_W'(VW);

    // Column-ordered view of the word: ext[c] is display column c.
    logic [VW-1:0] ext;

    generate
        for (genvar gi = 0; gi < VW; gi++) begin : g_ext
            if (gi < WORD_W) begin : g_pix
                assign ext[gi] = word[WORD_W-1-gi];
            end else begin : g_gap
                assign ext[gi] = 1'b0;
            end
        end

        for (genvar gi = 0; gi < WIN_W; gi++) begin : g_win
            logic [OFF_W-1:0] col_raw;
            logic [OFF_W-1:0] col;
            assign col_raw = offset + OFF_W'(gi);
            assign col     = (col_raw >= VW_C) ? (col_raw - VW_C) : col_raw;
            assign window[WIN_W-1-gi] = ext[col];
        end
    endgenerate

endmodule

// File: rtl/banner_row_scanner.sv
// Walks ROM rows once per frame, hands each scrolled window to the LED driver via valid/ready.
// Build option BANNER_GAP_EN (see banner_pkg) adds a blank gap to the scroll period.
module banner_row_scanner
    import banner_pkg::*;
#(
    parameter int WIN_W      = 16,
    parameter int SCROLL_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [WIN_W-1:0]  row_data,
    output logic [IDX_W-1:0]  row_idx,
    output logic              frame_done,
    output logic [OFF_W-1:0]  scroll_off
);

    localparam int               DIV_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [WIN_W-1:0]  row_data_q, row_data_d;
    logic [IDX_W-1:0]  row_idx_q, row_idx_d;
    logic              row_valid_q, row_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [WIN_W-1:0]  window;

    banner_window_extract #(
        .WIN_W (WIN_W)
    ) u_extract (
        .word   (rom_data),
        .offset (off_q),
        .window (window)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        div_d        = div_q;
        off_d        = off_q;
        row_data_d   = row_data_q;
        row_idx_d    = row_idx_q;
        row_valid_d  = row_valid_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ADDR;
                end
            end
            // ROM is registering rom_addr this cycle; data is usable in CAPT.
            ST_ADDR: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                row_data_d  = window;
                row_idx_d   = row_q[IDX_W-1:0];
                row_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (row_ready) begin
                    row_valid_d = 1'b0;
                    if (row_q < ROW_LAST) begin
                        row_d   = row_q + 1'b1;
                        state_d = ST_ADDR;
                    end else begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                        state_d      = ST_FEND;
                    end
                end
            end
            // Frame end: scroll bookkeeping always completes, even if enable dropped.
            ST_FEND: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    off_d = next_offset(off_q);
                end else begin
                    div_d = div_q + 1'b1;
                end
                state_d = enable ? ST_ADDR : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            div_q        <= '0;
            off_q        <= '0;
            row_data_q   <= '0;
            row_idx_q    <= '0;
            row_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            div_q        <= div_d;
            off_q        <= off_d;
            row_data_q   <= row_data_d;
            row_idx_q    <= row_idx_d;
            row_valid_q  <= row_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rom_addr   = row_q;
    assign row_valid  = row_valid_q;
    assign row_data   = row_data_q;
    assign row_idx    = row_idx_q;
    assign frame_done = frame_done_q;
    assign scroll_off = off_q;

endmodule
